// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: operation classes, op codes and
// divider state encodings.
package ex_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int DIV_CYCLES = DATA_W;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

    // Operation classes (alusel)
    localparam logic [2:0] ALUSEL_NOP   = 3'b000;
    localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [2:0] ALUSEL_MOVE  = 3'b011;
    localparam logic [2:0] ALUSEL_ARITH = 3'b100;

    // Operation codes (aluop)
    localparam logic [7:0] OP_NOP  = 8'b0000_0000;
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_ANDI = 8'b0101_1001;
    localparam logic [7:0] OP_ORI  = 8'b0101_1010;
    localparam logic [7:0] OP_XORI = 8'b0101_1011;
    localparam logic [7:0] OP_LUI  = 8'b0101_1100;
    localparam logic [7:0] OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO = 8'b0001_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider: magnitudes are divided on a 64-bit
// remainder/quotient shift register, signs are applied on the way out.
module div_unit
    import ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic              annul,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    div_state_e          state_q, state_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   dsor_q, dsor_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;

    // Shifted partial remainder is 33 bits wide; its low 32 bits minus the
    // divisor are exact whenever the subtraction is taken.
    logic [DATA_W:0]     partial;
    logic [DATA_W-1:0]   trial;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        dsor_d     = dsor_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        partial    = acc_q[2*DATA_W-1:DATA_W-1];
        trial      = acc_q[2*DATA_W-2:DATA_W-1] - dsor_q;

        case (state_q)
            DIV_IDLE: begin
                if (start && !annul) begin
                    if (divisor == '0) begin
                        acc_d      = {dividend, {DATA_W{1'b1}}};
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                        state_d    = DIV_DONE;
                    end else begin
                        acc_d      = {{DATA_W{1'b0}}, signed_op ? abs_val(dividend) : dividend};
                        dsor_d     = signed_op ? abs_val(divisor) : divisor;
                        neg_quot_d = signed_op && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        neg_rem_d  = signed_op && dividend[DATA_W-1];
                        cnt_d      = '0;
                        state_d    = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (partial >= {1'b0, dsor_q})
                    acc_d = {trial, acc_q[DATA_W-2:0], 1'b1};
                else
                    acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_CYCLES - 1))
                    state_d = DIV_DONE;
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        if (annul)
            state_d = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            acc_q      <= '0;
            dsor_q     <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            dsor_q     <= dsor_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    assign busy      = (state_q == DIV_BUSY);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = neg_quot_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];
    assign remainder = neg_rem_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1) : acc_q[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle logic/move results, HI/LO ownership, and a
// multi-cycle divider that holds the pipeline through a stall request.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  alusel_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        annul_i,
    output logic [31:0] wdata_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] result;
    logic        writes_gpr;
    logic        is_div, is_signed_div, is_mthi, is_mtlo;
    logic        div_busy, div_done;
    logic [31:0] div_quot, div_rem;

    // An op is recognised only when its class and code agree.
    always_comb begin
        result        = '0;
        writes_gpr    = 1'b0;
        is_div        = 1'b0;
        is_signed_div = 1'b0;
        is_mthi       = 1'b0;
        is_mtlo       = 1'b0;
        case (alusel_i)
            ALUSEL_LOGIC: begin
                writes_gpr = 1'b1;
                case (aluop_i)
                    OP_AND, OP_ANDI:        result = reg1_i & reg2_i;
                    OP_OR, OP_ORI, OP_LUI:  result = reg1_i | reg2_i;
                    OP_XOR, OP_XORI:        result = reg1_i ^ reg2_i;
                    OP_NOR:                 result = ~(reg1_i | reg2_i);
                    default:                writes_gpr = 1'b0;
                endcase
            end
            ALUSEL_MOVE: begin
                case (aluop_i)
                    OP_MFHI: begin result = hi_q; writes_gpr = 1'b1; end
                    OP_MFLO: begin result = lo_q; writes_gpr = 1'b1; end
                    OP_MTHI: is_mthi = 1'b1;
                    OP_MTLO: is_mtlo = 1'b1;
                    default: writes_gpr = 1'b0;
                endcase
            end
            ALUSEL_ARITH: begin
                case (aluop_i)
                    OP_DIV:  begin is_div = 1'b1; is_signed_div = 1'b1; end
                    OP_DIVU: is_div = 1'b1;
                    default: writes_gpr = 1'b0;
                endcase
            end
            default: writes_gpr = 1'b0;
        endcase
    end

    div_unit u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div && !annul_i),
        .signed_op (is_signed_div),
        .annul     (annul_i),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // A flushed instruction must leave HI/LO untouched, even a finished divide.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!annul_i) begin
            if (div_done) begin
                hi_d = div_rem;
                lo_d = div_quot;
            end else begin
                if (is_mthi) hi_d = reg1_i;
                if (is_mtlo) lo_d = reg1_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // The divide stalls from its IDLE cycle through BUSY; DONE lets it leave.
    always_comb begin
        wdata_o    = '0;
        wd_o       = '0;
        wreg_o     = 1'b0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wdata_o    = result;
            wd_o       = wd_i;
            wreg_o     = wreg_i && writes_gpr && !annul_i;
            stallreq_o = !annul_i && (div_busy || (is_div && !div_done));
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Randomised and directed bench for ex_stage: a driver issues instructions and
// queues expected retirements; a monitor checks each retirement and HI/LO.
module tb_ex_stage;
    import ex_stage_pkg::*;

    typedef struct packed {
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [7:0]  stalls;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alusel_i;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i, annul_i;
    logic [31:0] wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o, stallreq_o;
    logic [31:0] hi_o, lo_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic ins_v = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;

    ex_stage dut (
        .clk(clk), .rst(rst), .alusel_i(alusel_i), .aluop_i(aluop_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .annul_i(annul_i), .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic div_ref(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endtask

    task automatic drive_nop();
        alusel_i = ALUSEL_NOP; aluop_i = OP_NOP;
        reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0; annul_i = 1'b0;
    endtask

    // ---------------- driver ----------------
    // annul_at: cycle (0 = first cycle in EX) on which annul_i is raised; -1 = never.
    task automatic issue(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr, input int annul_at);
        exp_t e;
        logic [31:0] q, r;
        logic wb;
        int nom, cyc;
        e = '0;
        e.wd = wd; e.chk_wdata = 1'b1; e.hi = m_hi; e.lo = m_lo;
        wb = 1'b1;
        case ({sel, op})
            {ALUSEL_LOGIC, OP_AND}, {ALUSEL_LOGIC, OP_ANDI}: e.wdata = a & b;
            {ALUSEL_LOGIC, OP_OR},  {ALUSEL_LOGIC, OP_ORI},
            {ALUSEL_LOGIC, OP_LUI}:                          e.wdata = a | b;
            {ALUSEL_LOGIC, OP_XOR}, {ALUSEL_LOGIC, OP_XORI}: e.wdata = a ^ b;
            {ALUSEL_LOGIC, OP_NOR}:                          e.wdata = ~(a | b);
            {ALUSEL_MOVE, OP_MFHI}:                          e.wdata = m_hi;
            {ALUSEL_MOVE, OP_MFLO}:                          e.wdata = m_lo;
            {ALUSEL_MOVE, OP_MTHI}: begin
                wb = 1'b0; e.chk_wdata = 1'b0;
                if (annul_at != 0) e.hi = a;
            end
            {ALUSEL_MOVE, OP_MTLO}: begin
                wb = 1'b0; e.chk_wdata = 1'b0;
                if (annul_at != 0) e.lo = a;
            end
            {ALUSEL_ARITH, OP_DIV}, {ALUSEL_ARITH, OP_DIVU}: begin
                wb = 1'b0; e.chk_wdata = 1'b0;
                div_ref(op == OP_DIV, a, b, q, r);
                nom = (b == 0) ? 1 : 33;
                if (annul_at >= 0 && annul_at <= nom) begin
                    e.stalls = 8'(annul_at);
                end else begin
                    e.stalls = 8'(nom);
                    e.hi = r;
                    e.lo = q;
                end
            end
            default: begin
                e.wdata = '0;
                wb = 1'b0;
            end
        endcase
        e.wreg = wr && wb && (annul_at != 0);
        m_hi = e.hi;
        m_lo = e.lo;
        exp_q.push_back(e);

        alusel_i = sel; aluop_i = op; reg1_i = a; reg2_i = b;
        wd_i = wd; wreg_i = wr; annul_i = (annul_at == 0);
        ins_v = 1'b1;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!stallreq_o) break;
            @(posedge clk); #1;
            cyc++;
            if (cyc == annul_at) annul_i = 1'b1;
            if (cyc > 200) begin
                errors++;
                $display("FAIL stall_timeout: stallreq_o still high after %0d cycles expected release", cyc);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
        @(posedge clk); #1;
        ins_v = 1'b0;
        drive_nop();
    endtask

    // ---------------- scoreboard / monitor ----------------
    initial begin : monitor
        exp_t cur;
        logic hl_pending;
        int   stall_cnt;
        hl_pending = 1'b0;
        stall_cnt  = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (hl_pending) begin
                chk("hi_after", hi_o, cur.hi);
                chk("lo_after", lo_o, cur.lo);
                hl_pending = 1'b0;
            end
            if (ins_v && !rst) begin
                if (stallreq_o) begin
                    stall_cnt++;
                    if (wreg_o !== 1'b0) chk("wreg_while_stalled", 32'(wreg_o), 32'd0);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 32'(exp_q.size()), 32'd1);
                end else begin
                    cur = exp_q.pop_front();
                    chk("wd", 32'(wd_o), 32'(cur.wd));
                    chk("wreg", 32'(wreg_o), 32'(cur.wreg));
                    chk("stall_cycles", 32'(stall_cnt), 32'(cur.stalls));
                    if (cur.chk_wdata) chk("wdata", wdata_o, cur.wdata);
                    hl_pending = 1'b1;
                    stall_cnt  = 0;
                end
            end else begin
                stall_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [2:0] r_sel [15] = '{ALUSEL_LOGIC, ALUSEL_LOGIC, ALUSEL_LOGIC, ALUSEL_LOGIC,
                               ALUSEL_LOGIC, ALUSEL_LOGIC, ALUSEL_LOGIC, ALUSEL_LOGIC,
                               ALUSEL_MOVE, ALUSEL_MOVE, ALUSEL_MOVE, ALUSEL_MOVE,
                               ALUSEL_ARITH, ALUSEL_ARITH, ALUSEL_ARITH};
    logic [7:0] r_op [15]  = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ANDI, OP_ORI, OP_XORI,
                               OP_LUI, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
                               OP_DIV, OP_DIVU, OP_OR};

    initial begin : stim
        int k, an;
        logic [31:0] a, b;
        rst = 1'b1;
        drive_nop();
        alusel_i = ALUSEL_LOGIC; aluop_i = OP_OR; reg1_i = 32'h1234_5678;
        reg2_i = 32'h0F0F_0000; wd_i = 5'd9; wreg_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_wd", 32'(wd_o), 32'h0);
        chk("rst_wreg", 32'(wreg_o), 32'h0);
        chk("rst_stall", 32'(stallreq_o), 32'h0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_nop();

        issue(ALUSEL_LOGIC, OP_OR,   32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1, -1);
        issue(ALUSEL_LOGIC, OP_LUI,  32'h0,         32'h1234_0000, 5'd6, 1'b1, -1);
        issue(ALUSEL_LOGIC, OP_XORI, 32'hFFFF_0000, 32'h0000_FFFF, 5'd7, 1'b1, -1);
        issue(ALUSEL_LOGIC, OP_NOR,  32'h00FF_00FF, 32'h0F0F_0F0F, 5'd8, 1'b1, -1);
        issue(ALUSEL_LOGIC, 8'hFF,   32'hDEAD_BEEF, 32'h1,         5'd9, 1'b1, -1);
        issue(ALUSEL_ARITH, OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd3, 1'b1, -1);
        issue(ALUSEL_MOVE,  OP_MFLO, 32'h0,         32'h0,         5'd4, 1'b1, -1);
        issue(ALUSEL_MOVE,  OP_MFHI, 32'h0,         32'h0,         5'd4, 1'b1, -1);
        issue(ALUSEL_ARITH, OP_DIVU, 32'hFFFF_FFFF, 32'h10,        5'd1, 1'b0, -1);
        issue(ALUSEL_ARITH, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 1'b0, -1);
        issue(ALUSEL_ARITH, OP_DIVU, 32'd100,       32'd0,         5'd1, 1'b0, -1);
        issue(ALUSEL_MOVE,  OP_MFLO, 32'h0,         32'h0,         5'd2, 1'b1, -1);

        // reset during an in-flight divide
        alusel_i = ALUSEL_ARITH; aluop_i = OP_DIV; reg1_i = 32'd5000; reg2_i = 32'd7;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        chk("rst_mid_stall", 32'(stallreq_o), 32'h0);
        chk("rst_mid_wreg", 32'(wreg_o), 32'h0);
        chk("rst_mid_hi", hi_o, 32'h0);
        chk("rst_mid_lo", lo_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        issue(ALUSEL_ARITH, OP_DIV,  32'd1000, 32'd3, 5'd1, 1'b0, -1);

        // annul mid-divide, then the same divide completes
        issue(ALUSEL_MOVE,  OP_MTHI, 32'h0000_AAAA, 32'h0, 5'd0, 1'b0, -1);
        issue(ALUSEL_MOVE,  OP_MTLO, 32'h0000_5555, 32'h0, 5'd0, 1'b0, -1);
        issue(ALUSEL_ARITH, OP_DIV,  32'd100, 32'd7, 5'd1, 1'b0, 10);
        issue(ALUSEL_MOVE,  OP_MTHI, 32'h1234_0000, 32'h0, 5'd0, 1'b0, 0);
        issue(ALUSEL_ARITH, OP_DIV,  32'd100, 32'd7, 5'd1, 1'b0, -1);
        issue(ALUSEL_LOGIC, OP_AND,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd12, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 14);
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            an = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 33)) : -1;
            if (r_sel[k] != ALUSEL_ARITH && an > 0) an = 0;
            if (k == 14) begin
                issue(ALUSEL_ARITH, OP_OR, a, b, 5'($urandom), 1'b1, an);
            end else begin
                issue(r_sel[k], r_op[k], a, b, 5'($urandom), 1'($urandom), an);
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
